// File: rtl/equiv_sweep_ctrl_if.sv
// Handshake and result bundle between the equivalence sweep controller and its environment.
// The master side is the controller; the slave side supplies start/abort and both netlists' outputs.
interface equiv_sweep_ctrl_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
);
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   vec;
    logic [N_OUT-1:0]  ref_o;
    logic [N_OUT-1:0]  dut_o;
    logic              busy;
    logic              done;
    logic              equiv;
    logic [N_IN-1:0]   mis_vec;
    logic [N_OUT-1:0]  mis_mask;
    logic [N_IN:0]     mis_cnt;

    modport master (
        input  start, abort, ref_o, dut_o,
        output vec, busy, done, equiv, mis_vec, mis_mask, mis_cnt
    );

    modport slave (
        output start, abort, ref_o, dut_o,
        input  vec, busy, done, equiv, mis_vec, mis_mask, mis_cnt
    );
endinterface

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive-vector sequencer comparing a reference and a candidate netlist.
// EQCHK_RUN_ALL_EN: when defined the sweep runs to the last vector; otherwise it stops at the first mismatch.
module equiv_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    equiv_sweep_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, APPLY, COMPARE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
`ifdef EQCHK_RUN_ALL_EN
    localparam bit STOP_ON_FIRST = 1'b0;
`else
    localparam bit STOP_ON_FIRST = 1'b1;
`endif

    state_t             state_q;
    logic [3:0]         settle_q;
    logic [N_IN-1:0]    vec_q;
    logic               busy_q;
    logic               done_q;
    logic               equiv_q;
    logic [N_IN-1:0]    mis_vec_q;
    logic [N_OUT-1:0]   mis_mask_q;
    logic [N_IN:0]      mis_cnt_q;

    logic               mismatch_d;
    logic [N_OUT-1:0]   diff_d;
    logic               last_vec_d;

    // Case inequality so X/Z on either netlist counts as a mismatch in simulation.
    assign mismatch_d = (bus.ref_o !== bus.dut_o);
    assign diff_d     = bus.ref_o ^ bus.dut_o;
    assign last_vec_d = &vec_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.abort) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            equiv_q    <= 1'b0;
            mis_vec_q  <= '0;
            mis_mask_q <= '0;
            mis_cnt_q  <= '0;
        end else if (bus.start && !busy_q) begin
            // Start is honoured from IDLE and DONE alike; busy_q covers APPLY/COMPARE.
            state_q    <= APPLY;
            settle_q   <= SETTLE_LOAD;
            vec_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            equiv_q    <= 1'b0;
            mis_vec_q  <= '0;
            mis_mask_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mis_vec_q  <= '0;
                    mis_mask_q <= '0;
                    mis_cnt_q  <= '0;
                end
                APPLY: begin
                    if (settle_q != 4'd0) begin
                        settle_q <= settle_q - 4'd1;
                    end else begin
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (mismatch_d) begin
                        mis_cnt_q <= mis_cnt_q + 1'b1;
                        if (mis_cnt_q == '0) begin
                            mis_vec_q  <= vec_q;
                            mis_mask_q <= diff_d;
                        end
                    end
                    if (last_vec_d || (mismatch_d && STOP_ON_FIRST)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        equiv_q <= (mis_cnt_q == '0) && !mismatch_d;
                    end else begin
                        state_q  <= APPLY;
                        vec_q    <= vec_q + 1'b1;
                        settle_q <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec      = vec_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.equiv    = equiv_q;
    assign bus.mis_vec  = mis_vec_q;
    assign bus.mis_mask = mis_mask_q;
    assign bus.mis_cnt  = mis_cnt_q;
endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Directed bench for equiv_sweep_ctrl: one SETTLE=1 instance and one SETTLE=3 instance.
module tb_equiv_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   mode1    = 0;
    int   mode3    = 0;
    int   edges;

    always #5 clk = ~clk;

    equiv_sweep_ctrl_if #(.N_IN(2), .N_OUT(2)) bus1 ();
    equiv_sweep_ctrl_if #(.N_IN(2), .N_OUT(2)) bus3 ();

    equiv_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SETTLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    equiv_sweep_ctrl #(.N_IN(2), .N_OUT(2), .SETTLE(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    // mode 0: identical netlists; 1: reference O1 inverted; 2: candidate O0 flips at vec 11
    function automatic logic [1:0] ref_f(int m, logic [1:0] v);
        return (m == 1) ? {~v[1], v[0]} : v;
    endfunction

    function automatic logic [1:0] dut_f(int m, logic [1:0] v);
        return (m == 2 && v == 2'b11) ? (v ^ 2'b01) : v;
    endfunction

    assign bus1.ref_o = ref_f(mode1, bus1.vec);
    assign bus1.dut_o = dut_f(mode1, bus1.vec);
    assign bus3.ref_o = ref_f(mode3, bus3.vec);
    assign bus3.dut_o = dut_f(mode3, bus3.vec);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(int d, logic v);
        if (d == 3) bus3.start = v;
        else        bus1.start = v;
    endtask

    task automatic check_results(string tag, int d, int e_busy, int e_done, int e_equiv,
                                 int e_vec, int e_mv, int e_mm, int e_mc);
        logic [31:0] b, dn, eq, v, mv, mm, mc;
        if (d == 3) begin
            b = 32'(bus3.busy); dn = 32'(bus3.done); eq = 32'(bus3.equiv); v = 32'(bus3.vec);
            mv = 32'(bus3.mis_vec); mm = 32'(bus3.mis_mask); mc = 32'(bus3.mis_cnt);
        end else begin
            b = 32'(bus1.busy); dn = 32'(bus1.done); eq = 32'(bus1.equiv); v = 32'(bus1.vec);
            mv = 32'(bus1.mis_vec); mm = 32'(bus1.mis_mask); mc = 32'(bus1.mis_cnt);
        end
        check({tag, "_busy"},     b,  32'(e_busy));
        check({tag, "_done"},     dn, 32'(e_done));
        check({tag, "_equiv"},    eq, 32'(e_equiv));
        check({tag, "_vec"},      v,  32'(e_vec));
        check({tag, "_mis_vec"},  mv, 32'(e_mv));
        check({tag, "_mis_mask"}, mm, 32'(e_mm));
        check({tag, "_mis_cnt"},  mc, 32'(e_mc));
    endtask

    task automatic begin_sweep(int d);
        set_start(d, 1'b1);
        tick();
        set_start(d, 1'b0);
    endtask

    // Counts edges from the start edge until done; vec must step every s+1 cycles.
    task automatic wait_done(string tag, int d, int s, int restart_at, int max, output int n);
        int c;
        logic dn, b;
        logic [1:0] v;
        c = 0;
        while (c < max) begin
            dn = (d == 3) ? bus3.done : bus1.done;
            b  = (d == 3) ? bus3.busy : bus1.busy;
            v  = (d == 3) ? bus3.vec  : bus1.vec;
            if (dn) break;
            check({tag, "_busy_run"}, 32'(b), 32'd1);
            check({tag, "_vec_run"},  32'(v), 32'(c / (s + 1)));
            set_start(d, c == restart_at);
            tick();
            c++;
        end
        set_start(d, 1'b0);
        n = c;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0;
        tick();
        tick();
        check_results("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
        check_results("reset3", 3, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: equivalent pair
        mode1 = 0;
        begin_sweep(1);
        wait_done("t1", 1, 1, -1, 40, edges);
        check("t1_latency", 32'(edges), 32'd8);
        check_results("t1", 1, 0, 1, 1, 3, 0, 0, 0);
        tick();
        tick();
        check_results("t1_hold", 1, 0, 1, 1, 3, 0, 0, 0);

        // Test 2/3: O1 inverted, restarted straight from DONE
        mode1 = 1;
        begin_sweep(1);
        wait_done("t2", 1, 1, -1, 40, edges);
`ifdef EQCHK_RUN_ALL_EN
        check("t3_latency", 32'(edges), 32'd8);
        check_results("t3", 1, 0, 1, 0, 3, 0, 2, 4);
`else
        check("t2_latency", 32'(edges), 32'd2);
        check_results("t2", 1, 0, 1, 0, 0, 0, 2, 1);
`endif

        // Abort from DONE clears results
        bus1.abort = 1'b1;
        tick();
        bus1.abort = 1'b0;
        check_results("abort_done", 1, 0, 0, 0, 0, 0, 0, 0);

        // Test 4: SETTLE=3, mismatch only on the last vector; a mid-sweep start is ignored
        mode3 = 2;
        begin_sweep(3);
        wait_done("t4", 3, 3, 4, 80, edges);
        check("t4_latency", 32'(edges), 32'd16);
        check_results("t4", 3, 0, 1, 0, 3, 3, 1, 1);

        // Test 5: abort together with start right after vec=01 is applied
        mode1 = 0;
        begin_sweep(1);
        tick();
        tick();
        check("t5_vec_before", 32'(bus1.vec), 32'd1);
        check("t5_busy_before", 32'(bus1.busy), 32'd1);
        bus1.abort = 1'b1;
        bus1.start = 1'b1;
        tick();
        bus1.abort = 1'b0;
        bus1.start = 1'b0;
        check_results("t5_abort", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_results("t5_idle", 1, 0, 0, 0, 0, 0, 0, 0);

        // Test 6: reset mid-sweep, then a fresh sweep
        mode1 = 1;
        begin_sweep(1);
        tick();
        rst_n = 1'b0;
        tick();
        check_results("t6_reset", 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        mode1 = 0;
        begin_sweep(1);
        wait_done("t6", 1, 1, -1, 40, edges);
        check("t6_latency", 32'(edges), 32'd8);
        check_results("t6", 1, 0, 1, 1, 3, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
